// File: rtl/encoder_bank_pkg.sv
// Shared constants and quadrature step classification for the encoder bank.
package encoder_bank_pkg;

  typedef enum logic {MODE_DIV4 = 1'b0, MODE_FULL = 1'b1} mode_e;

  // Address fields
  localparam int A_SPACE   = 7;
  localparam int A_CH_HI   = 6;
  localparam int A_CH_LO   = 2;
  localparam int A_BYTE_HI = 1;
  localparam int A_BYTE_LO = 0;

  // Control byte bits
  localparam int C_MODE    = 0;
  localparam int C_CLR_CNT = 1;
  localparam int C_ERR     = 2;

  // Position difference along the 00->01->11->10 cycle, modulo 4
  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_DBL  = 2'd2,
    STEP_BWD  = 2'd3
  } step_e;

  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   gray_pos = 2'd0;
      2'b01:   gray_pos = 2'd1;
      2'b11:   gray_pos = 2'd2;
      default: gray_pos = 2'd3;
    endcase
  endfunction

  function automatic step_e step_of(input logic [1:0] prev, input logic [1:0] cur);
    step_of = step_e'(gray_pos(cur) - gray_pos(prev));
  endfunction

endpackage

// File: rtl/encoder_bank_channel.sv
// One quadrature channel: glitch filter, step decoder, wrapping counter,
// sticky double-step error and the channel's mode register.
module quad_channel
  import encoder_bank_pkg::*;
#(
  parameter int CW   = 16,
  parameter int FILT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    ab_s,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic [CW-1:0] count,
  output logic          mode,
  output logic          err
);

  logic [CW-1:0] cnt_q, cnt_d;
  mode_e         mode_q, mode_d;
  logic          err_q, err_d;
  logic [1:0]    prev_q, prev_d, cand_q, cand_d;
  logic [3:0]    fcnt_q, fcnt_d;
  logic [1:0]    cur;
  logic          mode_chg;
  step_e         step;

  always_comb begin
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    err_d    = err_q;
    prev_d   = prev_q;
    cand_d   = cand_q;
    fcnt_d   = fcnt_q;
    mode_chg = wr_en && (wr_data[C_MODE] != mode_q);

    // Candidate level must survive FILT cycles before div4 mode accepts it
    if (ab_s != cand_q) begin
      cand_d = ab_s;
      fcnt_d = 4'd1;
    end else if (fcnt_q < 4'(FILT - 1)) begin
      fcnt_d = fcnt_q + 4'd1;
    end

    if (mode_q == MODE_FULL)
      cur = ab_s;
    else
      cur = (ab_s == cand_q && fcnt_q == 4'(FILT - 1)) ? ab_s : prev_q;

    step = step_of(prev_q, cur);
    if (wr_en && wr_data[C_ERR]) err_d = 1'b0;

    if (mode_chg) begin
      prev_d = ab_s;
      cand_d = ab_s;
      fcnt_d = 4'd0;
    end else begin
      prev_d = cur;
      case (step)
        STEP_FWD: if (mode_q == MODE_FULL || (prev_q == 2'b10 && cur == 2'b00))
                    cnt_d = cnt_q + CW'(1);
        STEP_BWD: if (mode_q == MODE_FULL || (prev_q == 2'b00 && cur == 2'b10))
                    cnt_d = cnt_q - CW'(1);
        STEP_DBL: err_d = 1'b1;
        default:  ;
      endcase
    end

    if (wr_en) mode_d = mode_e'(wr_data[C_MODE]);
    if (wr_en && wr_data[C_CLR_CNT]) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      mode_q <= MODE_DIV4;
      err_q  <= 1'b0;
      fcnt_q <= 4'd0;
      prev_q <= ab_s;
      cand_q <= ab_s;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      err_q  <= err_d;
      fcnt_q <= fcnt_d;
      prev_q <= prev_d;
      cand_q <= cand_d;
    end
  end

  assign count = cnt_q;
  assign mode  = (mode_q == MODE_FULL);
  assign err   = err_q;

endmodule

// File: rtl/encoder_bank.sv
// Bank of quadrature counters behind a multiplexed ale/rd/wr byte bus with
// coherent multi-byte snapshot reads.
module encoder_bank
  import encoder_bank_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int CW   = 16,
  parameter int FILT = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2*NCH-1:0] q,
  input  logic           ale,
  input  logic           rd,
  input  logic           wr,
  inout  wire  [7:0]     ad
);

  logic [2*NCH-1:0] q_s1_q, q_s2_q;
  logic             ale_s1_q, ale_s2_q, ale_p_q;
  logic             wr_s1_q, wr_s2_q, wr_p_q;
  logic [7:0]       addr_q, addr_d, out_q, out_d;
  logic [CW-1:0]    snap_q, snap_d, snap_sh;
  logic             ld_q, ld_d;
  logic             ale_fall, wr_rise, wr_hit;

  // Unpopulated channel slots read as zero, so any 5-bit channel indexes safely
  logic [31:0][CW-1:0] cnt_all;
  logic [31:0]         mode_all, err_all;

  always_ff @(posedge clk) begin
    q_s1_q <= q;
    q_s2_q <= q_s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {ale_s1_q, ale_s2_q, ale_p_q} <= 3'b111;
      {wr_s1_q, wr_s2_q, wr_p_q}    <= 3'b111;
      addr_q <= 8'h00;
      out_q  <= 8'h00;
      snap_q <= '0;
      ld_q   <= 1'b0;
    end else begin
      {ale_s1_q, ale_s2_q, ale_p_q} <= {ale, ale_s1_q, ale_s2_q};
      {wr_s1_q, wr_s2_q, wr_p_q}    <= {wr, wr_s1_q, wr_s2_q};
      addr_q <= addr_d;
      out_q  <= out_d;
      snap_q <= snap_d;
      ld_q   <= ld_d;
    end
  end

  always_comb begin
    ale_fall = ale_p_q & ~ale_s2_q;
    wr_rise  = ~wr_p_q & wr_s2_q;
    wr_hit   = wr_rise & addr_q[A_SPACE];
    addr_d   = ale_fall ? ad : addr_q;
    ld_d     = ale_fall;
    snap_d   = snap_q;
    if (ale_fall && !ad[A_SPACE] && ad[A_BYTE_HI:A_BYTE_LO] == 2'd0)
      snap_d = cnt_all[ad[A_CH_HI:A_CH_LO]];

    snap_sh = snap_q >> {addr_q[A_BYTE_HI:A_BYTE_LO], 3'b000};
    out_d   = out_q;
    if (ld_q) begin
      if (addr_q[A_SPACE])
        out_d = {5'b0, err_all[addr_q[A_CH_HI:A_CH_LO]], 1'b0,
                 mode_all[addr_q[A_CH_HI:A_CH_LO]]};
      else if (32'(addr_q[A_BYTE_HI:A_BYTE_LO]) < CW / 8)
        out_d = snap_sh[7:0];
      else
        out_d = 8'h00;
    end
  end

  for (genvar n = 0; n < 32; n++) begin : g_ch
    if (n < NCH) begin : g_on
      quad_channel #(.CW(CW), .FILT(FILT)) u_ch (
        .clk     (clk),
        .rst     (rst),
        .ab_s    (q_s2_q[2*n +: 2]),
        .wr_en   (wr_hit && addr_q[A_CH_HI:A_CH_LO] == 5'(n)),
        .wr_data (ad),
        .count   (cnt_all[n]),
        .mode    (mode_all[n]),
        .err     (err_all[n])
      );
    end else begin : g_off
      assign cnt_all[n]  = '0;
      assign mode_all[n] = 1'b0;
      assign err_all[n]  = 1'b0;
    end
  end

  assign ad = rd ? 8'hzz : out_q;

endmodule
